// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : contador_pkg
//  Description : Shared constants and helpers for the parametrised counter.
//                MODE_WRAP / MODE_SAT select the SATURATE behaviour;
//                clamp_range() limits a value to an inclusive [lo,hi] range.
//  Revision    : 1.0  initial release
// ============================================================================
package contador_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Wide operands so callers of any supported WIDTH can share one helper;
    // the caller casts the result back to its own width.
    function automatic logic [63:0] clamp_range(
        input logic [63:0] v,
        input logic [63:0] lo,
        input logic [63:0] hi
    );
        logic [63:0] w_res;
        w_res = v;
        if (v < lo) begin
            w_res = lo;
        end else if (v > hi) begin
            w_res = hi;
        end
        return w_res;
    endfunction

endpackage : contador_pkg
`default_nettype wire

// File: rtl/contador_next.sv
`default_nettype none
// ============================================================================
//  Module      : contador_next
//  Description : Combinational next-count logic. Computes the stepped value
//                of v in WIDTH+1 bits, wraps or clamps at the range bounds and
//                flags a crossed bound.
//  Ports       : v     in  WIDTH  current count
//                up    in  1      step up request (already qualified)
//                down  in  1      step down request (already qualified)
//                nxt   out WIDTH  next count
//                ovf   out 1      up step crossed MAX_VAL
//                unf   out 1      down step crossed MIN_VAL
//  Revision    : 1.0  initial release
// ============================================================================
module contador_next
    import contador_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 255,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] v,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH:0] c_STEP = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] c_MIN  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] c_MAX  = (WIDTH+1)'(MAX_VAL);
    localparam logic           c_SAT  = (SATURATE == MODE_SAT);

    logic [WIDTH:0] w_v_ext;
    logic [WIDTH:0] w_up_sum;
    logic [WIDTH:0] w_up_wrap;
    logic [WIDTH:0] w_dn_diff;
    logic [WIDTH:0] w_dn_wrap;
    logic           w_dn_fits;

    assign w_v_ext   = {1'b0, v};
    assign w_up_sum  = w_v_ext + c_STEP;
    // Excess beyond MAX_VAL re-enters from MIN_VAL.
    assign w_up_wrap = c_MIN + (w_up_sum - c_MAX - 1'b1);
    assign w_dn_fits = (w_v_ext >= (c_MIN + c_STEP));
    assign w_dn_diff = w_v_ext - c_STEP;
    // Shortfall below MIN_VAL re-enters from MAX_VAL.
    assign w_dn_wrap = c_MAX - (c_MIN + c_STEP - w_v_ext - 1'b1);

    always_comb begin
        nxt = v;
        ovf = 1'b0;
        unf = 1'b0;
        if (up && !down) begin
            if (w_up_sum <= c_MAX) begin
                nxt = WIDTH'(w_up_sum);
            end else begin
                ovf = 1'b1;
                nxt = c_SAT ? WIDTH'(c_MAX) : WIDTH'(w_up_wrap);
            end
        end else if (down && !up) begin
            if (w_dn_fits) begin
                nxt = WIDTH'(w_dn_diff);
            end else begin
                unf = 1'b1;
                nxt = c_SAT ? WIDTH'(c_MIN) : WIDTH'(w_dn_wrap);
            end
        end
    end

endmodule : contador_next
`default_nettype wire

// File: rtl/contador_param.sv
`default_nettype none
// ============================================================================
//  Module      : contador_param
//  Description : Parametrised up/down counter with wrap or saturate bounds,
//                synchronous load, count enable and registered range/event
//                flags. Load has priority over counting.
//  Ports       : clk       in  1      clock, rising edge
//                rst_n     in  1      asynchronous reset, active low
//                en        in  1      count enable (gates acrescer/decrecer)
//                acrescer  in  1      count up by STEP
//                decrecer  in  1      count down by STEP
//                load      in  1      load load_val (clamped), ignores en
//                load_val  in  WIDTH  value to load
//                saida     out WIDTH  current count
//                at_max    out 1      saida == MAX_VAL
//                at_min    out 1      saida == MIN_VAL
//                overflow  out 1      pulse: up step crossed MAX_VAL
//                underflow out 1      pulse: down step crossed MIN_VAL
//  Revision    : 1.0  initial release
// ============================================================================
module contador_param
    import contador_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int RST_VAL  = 'h6A,
    parameter int STEP     = 1,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             acrescer,
    input  logic             decrecer,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] saida,
    output logic             at_max,
    output logic             at_min,
    output logic             overflow,
    output logic             underflow
);

    // ---------------------------------------------------------------- checks
    if (WIDTH < 1 || WIDTH > 30) begin : g_chk_width
        $fatal(1, "contador_param: WIDTH must be in 1..30");
    end
    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_chk_bounds
        $fatal(1, "contador_param: need 0 <= MIN_VAL < MAX_VAL");
    end
    if (MAX_VAL > (1 << WIDTH) - 1) begin : g_chk_max
        $fatal(1, "contador_param: MAX_VAL does not fit in WIDTH bits");
    end
    if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_chk_rst
        $fatal(1, "contador_param: RST_VAL outside [MIN_VAL,MAX_VAL]");
    end
    if (STEP < 1 || STEP > MAX_VAL - MIN_VAL) begin : g_chk_step
        $fatal(1, "contador_param: STEP outside [1,MAX_VAL-MIN_VAL]");
    end

    localparam logic [WIDTH-1:0] c_RST        = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] c_MIN        = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_MAX        = WIDTH'(MAX_VAL);
    localparam logic             c_RST_AT_MAX = (RST_VAL == MAX_VAL);
    localparam logic             c_RST_AT_MIN = (RST_VAL == MIN_VAL);

    logic [WIDTH-1:0] r_saida;
    logic             r_at_max;
    logic             r_at_min;
    logic             r_ovf;
    logic             r_unf;

    logic             w_up;
    logic             w_down;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_ovf;
    logic             w_unf;
    logic [WIDTH-1:0] w_load_c;
    logic [WIDTH-1:0] w_next;

    assign w_up   = en & acrescer & ~decrecer;
    assign w_down = en & decrecer & ~acrescer;

    contador_next #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .MIN_VAL  (MIN_VAL),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .v    (r_saida),
        .up   (w_up),
        .down (w_down),
        .nxt  (w_cnt_next),
        .ovf  (w_ovf),
        .unf  (w_unf)
    );

    assign w_load_c = WIDTH'(clamp_range(64'(load_val), 64'(MIN_VAL), 64'(MAX_VAL)));
    assign w_next   = load ? w_load_c : w_cnt_next;

    // Flags come from the next-state value so they line up with saida.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_saida  <= c_RST;
            r_at_max <= c_RST_AT_MAX;
            r_at_min <= c_RST_AT_MIN;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_saida  <= w_next;
            r_at_max <= (w_next == c_MAX);
            r_at_min <= (w_next == c_MIN);
            r_ovf    <= w_ovf & ~load;
            r_unf    <= w_unf & ~load;
        end
    end

    assign saida     = r_saida;
    assign at_max    = r_at_max;
    assign at_min    = r_at_min;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule : contador_param
`default_nettype wire

// File: tb/tb_contador_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_param
//  Description : Self-checking bench for contador_param. Three instances with
//                different parameter sets share one stimulus stream; each is
//                compared against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_contador_param;

    localparam int P_RST [3] = '{'h6A, 15, 5};
    localparam int P_STEP[3] = '{1, 3, 3};
    localparam int P_MIN [3] = '{0, 10, 0};
    localparam int P_MAX [3] = '{255, 20, 20};
    localparam int P_SAT [3] = '{0, 0, 1};

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       acrescer;
    logic       decrecer;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] saida     [3];
    logic       at_max    [3];
    logic       at_min    [3];
    logic       overflow  [3];
    logic       underflow [3];

    int  m_v   [3];
    bit  m_ovf [3];
    bit  m_unf [3];
    int  n_chk;
    int  n_pass;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        contador_param #(
            .WIDTH    (8),
            .RST_VAL  (P_RST[g]),
            .STEP     (P_STEP[g]),
            .MIN_VAL  (P_MIN[g]),
            .MAX_VAL  (P_MAX[g]),
            .SATURATE (P_SAT[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .acrescer  (acrescer),
            .decrecer  (decrecer),
            .load      (load),
            .load_val  (load_val),
            .saida     (saida[g]),
            .at_max    (at_max[g]),
            .at_min    (at_min[g]),
            .overflow  (overflow[g]),
            .underflow (underflow[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp_v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i]   = P_RST[i];
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
    endtask

    // Reference: plain integer arithmetic, wrap via modulo over the range size.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int rng;
            int n;
            rng      = P_MAX[i] - P_MIN[i] + 1;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            if (load) begin
                n = int'(load_val);
                if (n < P_MIN[i]) n = P_MIN[i];
                if (n > P_MAX[i]) n = P_MAX[i];
                m_v[i] = n;
            end else if (en && acrescer && !decrecer) begin
                n = m_v[i] + P_STEP[i];
                if (n > P_MAX[i]) begin
                    m_ovf[i] = 1'b1;
                    n = (P_SAT[i] != 0) ? P_MAX[i] : P_MIN[i] + ((n - P_MIN[i]) % rng);
                end
                m_v[i] = n;
            end else if (en && decrecer && !acrescer) begin
                n = m_v[i] - P_STEP[i];
                if (n < P_MIN[i]) begin
                    m_unf[i] = 1'b1;
                    n = (P_SAT[i] != 0) ? P_MIN[i] : P_MIN[i] + ((n - P_MIN[i] + rng) % rng);
                end
                m_v[i] = n;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, ".saida"},     i, saida[i],              8'(m_v[i]));
            chk({tag, ".at_max"},    i, {7'd0, at_max[i]},     {7'd0, m_v[i] == P_MAX[i]});
            chk({tag, ".at_min"},    i, {7'd0, at_min[i]},     {7'd0, m_v[i] == P_MIN[i]});
            chk({tag, ".overflow"},  i, {7'd0, overflow[i]},   {7'd0, m_ovf[i]});
            chk({tag, ".underflow"}, i, {7'd0, underflow[i]},  {7'd0, m_unf[i]});
        end
    endtask

    // Model sees the inputs as the DUT samples them, then outputs are
    // checked just after the edge.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic e, input logic a, input logic d, input logic l, input logic [7:0] lv);
        en = e; acrescer = a; decrecer = d; load = l; load_val = lv;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        set_in(0, 0, 0, 0, 8'h00);
        model_reset();

        // 1: reset state
        #12;
        check_all("reset");
        chk("reset_saida", 0, saida[0], 8'h6A);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("hold_after_reset");

        // 2: 0xFF + 1 wraps to 0 in the default instance
        set_in(0, 0, 0, 1, 8'hFF);
        cycle("load_ff");
        set_in(1, 1, 0, 0, 8'h00);
        cycle("wrap_up");
        chk("t2_saida", 0, saida[0], 8'h00);
        chk("t2_ovf",   0, {7'd0, overflow[0]}, 8'd1);
        chk("t2_atmin", 0, {7'd0, at_min[0]},   8'd1);
        set_in(1, 0, 0, 0, 8'h00);
        cycle("ovf_clears");
        chk("t2_ovf_off", 0, {7'd0, overflow[0]}, 8'd0);

        // 3: wrap-down 19,16,13,10,18 in [10,20] step 3
        set_in(0, 0, 0, 1, 8'd19);
        cycle("load_19");
        set_in(1, 0, 1, 0, 8'h00);
        cycle("dn1");
        chk("t3_16", 1, saida[1], 8'd16);
        cycle("dn2");
        cycle("dn3");
        chk("t3_10", 1, saida[1], 8'd10);
        chk("t3_nounf", 1, {7'd0, underflow[1]}, 8'd0);
        cycle("dn4");
        chk("t3_18", 1, saida[1], 8'd18);
        chk("t3_unf", 1, {7'd0, underflow[1]}, 8'd1);

        // 4: saturating up from 19, held three cycles
        set_in(0, 0, 0, 1, 8'd19);
        cycle("load_19b");
        set_in(1, 1, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cycle("sat_up");
            chk("t4_20",  2, saida[2], 8'd20);
            chk("t4_ovf", 2, {7'd0, overflow[2]}, 8'd1);
            chk("t4_max", 2, {7'd0, at_max[2]},   8'd1);
        end

        // 5: both pressed, disabled, and clamped load
        set_in(1, 1, 1, 0, 8'h00);
        cycle("both_high");
        set_in(0, 1, 0, 0, 8'h00);
        cycle("en_low");
        set_in(0, 0, 0, 1, 8'd200);
        cycle("load_200");
        chk("t5_clamp", 1, saida[1], 8'd20);
        chk("t5_clamp", 2, saida[2], 8'd20);

        // 6: async reset between edges while counting
        set_in(1, 1, 0, 0, 8'h00);
        cycle("pre_rst1");
        cycle("pre_rst2");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        cycle("resume");
        chk("t6_resume", 0, saida[0], 8'h6B);

        // Randomised traffic with occasional asynchronous resets
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                   ($urandom % 8) == 0, 8'($urandom));
            if (($urandom % 50) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                #1;
                rst_n = 1'b1;
            end
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_contador_param
`default_nettype wire
